// File: rtl/prog_mem_banked.sv
// Banked multi-port program memory with word-interleaved banks, host-priority and round-robin arbitration per bank.
// Single-cycle read latency; saturating conflict and illegal-write statistics.
module prog_mem_banked #(
  parameter int unsigned NumPorts  = 9,
  parameter int unsigned NumBytes  = 32768,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  gnt_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o,
  input  logic                                 stats_clr_i,
  output logic [CntWidth-1:0]                  conflict_cnt_o,
  output logic [CntWidth-1:0]                  illegal_wr_cnt_o
);

  localparam int unsigned NumBe    = DataWidth / 8;
  localparam int unsigned ByteOff  = $clog2(NumBe);
  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned BankW    = (NumBanks > 1) ? BankBits : 1;
  localparam int unsigned NumRows  = NumBytes / NumBe / NumBanks;
  localparam int unsigned RowBits  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned NumCl    = NumPorts - 1;
  localparam int unsigned Host     = NumPorts - 1;
  localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned RrW      = (NumCl > 1) ? $clog2(NumCl) : 1;

  logic [NumPorts-1:0][BankW-1:0]   bank;
  logic [NumPorts-1:0][RowBits-1:0] row;
  logic [NumBanks-1:0]              win_vld;
  logic [NumBanks-1:0]              win_host;
  logic [NumBanks-1:0][PortW-1:0]   win_idx;
  logic [NumBanks-1:0][RrW-1:0]     rr_q;
  logic [NumBanks-1:0][DataWidth-1:0] rd_q;
  logic [DataWidth-1:0]             mem [NumBanks][NumRows];
  logic [NumPorts-1:0]              rvalid_q;
  logic [NumPorts-1:0]              wr_q;
  logic [NumPorts-1:0][BankW-1:0]   bank_q;
  logic [CntWidth-1:0]              conf_q;
  logic [CntWidth-1:0]              ill_q;
  logic [PortW-1:0]                 ill_n;
  logic [CntWidth:0]                ill_sum;
  logic                             conflict;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      bank[p] = '0;
      if (NumBanks > 1) bank[p] = BankW'(addr_i[p] >> ByteOff);
      row[p] = RowBits'(addr_i[p] >> (ByteOff + BankBits));
    end
  end

  // Host wins outright; otherwise scan clusters starting at the bank's pointer.
  always_comb begin
    logic [PortW:0]   sum;
    logic [PortW-1:0] c;
    win_vld  = '0;
    win_host = '0;
    win_idx  = '0;
    sum      = '0;
    c        = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (req_i[Host] && bank[Host] == BankW'(b)) begin
        win_vld[b]  = 1'b1;
        win_host[b] = 1'b1;
        win_idx[b]  = PortW'(Host);
      end else begin
        for (int i = 0; i < NumCl; i++) begin
          sum = (PortW+1)'(rr_q[b]) + (PortW+1)'(i);
          if (sum >= (PortW+1)'(NumCl)) sum = sum - (PortW+1)'(NumCl);
          c = PortW'(sum);
          if (!win_vld[b] && req_i[c] && bank[c] == BankW'(b)) begin
            win_vld[b] = 1'b1;
            win_idx[b] = c;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < NumPorts; p++)
      if (req_i[p] && win_vld[bank[p]] && win_idx[bank[p]] == PortW'(p)) gnt_o[p] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++)
        if (win_vld[b] && !win_host[b])
          rr_q[b] <= (win_idx[b] == PortW'(NumCl - 1)) ? '0 : RrW'(win_idx[b] + PortW'(1));
    end
  end

  // SRAM banks; a cluster write is demoted to a read of the same row.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (win_vld[b]) begin
        if (win_host[b] && we_i[Host]) begin
          for (int k = 0; k < NumBe; k++)
            if (be_i[win_idx[b]][k])
              mem[b][row[win_idx[b]]][8*k +: 8] <= wdata_i[win_idx[b]][8*k +: 8];
        end else begin
          rd_q[b] <= mem[b][row[win_idx[b]]];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      wr_q     <= '0;
      bank_q   <= '0;
    end else begin
      rvalid_q <= gnt_o;
      wr_q     <= gnt_o & we_i;
      bank_q   <= bank;
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++)
      rdata_o[p] = (rvalid_q[p] && !wr_q[p]) ? rd_q[bank_q[p]] : '0;
  end

  assign rvalid_o = rvalid_q;

  always_comb begin
    ill_n = '0;
    for (int p = 0; p < NumCl; p++)
      if (gnt_o[p] && we_i[p]) ill_n = ill_n + PortW'(1);
  end

  assign conflict = |(req_i & ~gnt_o);
  assign ill_sum  = {1'b0, ill_q} + (CntWidth+1)'(ill_n);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conf_q <= '0;
      ill_q  <= '0;
    end else if (stats_clr_i) begin
      conf_q <= '0;
      ill_q  <= '0;
    end else begin
      if (conflict && conf_q != '1) conf_q <= conf_q + CntWidth'(1);
      ill_q <= ill_sum[CntWidth] ? '1 : ill_sum[CntWidth-1:0];
    end
  end

  assign conflict_cnt_o   = conf_q;
  assign illegal_wr_cnt_o = ill_q;

endmodule

// File: tb/tb_prog_mem_banked.sv
// Table-driven bench for prog_mem_banked: per-cycle vectors with expected grants and counters,
// responses checked through a scoreboard queue against a reference word model.
module tb_prog_mem_banked;
  localparam int NP = 9, AW = 32, DW = 64, NB = 4, NBYTES = 32768, CW = 4, H = NP - 1;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NP-1:0]            req_i, gnt_o, we_i, rvalid_o;
  logic [NP-1:0][AW-1:0]    addr_i;
  logic [NP-1:0][DW-1:0]    wdata_i, rdata_o;
  logic [NP-1:0][DW/8-1:0]  be_i;
  logic                     stats_clr_i;
  logic [CW-1:0]            conflict_cnt_o, illegal_wr_cnt_o;

  always #5 clk_i = ~clk_i;

  prog_mem_banked #(.NumPorts(NP), .NumBytes(NBYTES), .AddrWidth(AW), .DataWidth(DW),
                    .NumBanks(NB), .CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .stats_clr_i(stats_clr_i), .conflict_cnt_o(conflict_cnt_o), .illegal_wr_cnt_o(illegal_wr_cnt_o));

  typedef struct {
    logic [NP-1:0]         req, we, gnt;
    logic [NP-1:0][AW-1:0] addr;
    logic [DW-1:0]         wd;
    logic [DW/8-1:0]       be;
    bit                    clr, chk;
    logic [CW-1:0]         conf, ill;
  } vec_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         sb[$];
  vec_t          vecs[$];
  logic [DW-1:0] model [4096];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'h5EED_0000 + 32'(i) * 32'h111};
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a >> 3) & 32'hFFF);
  endfunction

  function automatic vec_t mk(input logic [NP-1:0] req, we, gnt, input logic [DW-1:0] wd,
                              input logic [7:0] be, input logic [AW-1:0] a0, a1, a2, a3, ah);
    vec_t v;
    v.req = req; v.we = we; v.gnt = gnt; v.wd = wd; v.be = be;
    v.addr = '0;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3; v.addr[H] = ah;
    v.clr = 1'b0; v.chk = 1'b0; v.conf = '0; v.ill = '0;
    return v;
  endfunction

  function automatic vec_t cnt(input vec_t v, input int conf, input int ill);
    vec_t r = v;
    r.chk = 1'b1; r.conf = CW'(conf); r.ill = CW'(ill);
    return r;
  endfunction

  function automatic vec_t clr(input vec_t v);
    vec_t r = v;
    r.clr = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_i = v.req; we_i = v.we; addr_i = v.addr; stats_clr_i = v.clr;
    for (int p = 0; p < NP; p++) begin
      wdata_i[p] = v.wd;
      be_i[p]    = v.be;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_vec(input vec_t v, input int n);
    resp_t                 r;
    logic [NP-1:0]         exp_rv;
    logic [NP-1:0][DW-1:0] exp_rd;
    drive(v);
    #4;
    chk($sformatf("gnt v%0d", n), DW'(gnt_o), DW'(v.gnt));
    for (int p = 0; p < NP; p++) begin
      if (v.gnt[p]) begin
        r.port = p;
        r.data = v.we[p] ? '0 : model[widx(v.addr[p])];
        sb.push_back(r);
        if (p == H && v.we[p])
          for (int k = 0; k < DW/8; k++)
            if (v.be[k]) model[widx(v.addr[p])][8*k +: 8] = v.wd[8*k +: 8];
      end
    end
    @(posedge clk_i);
    #1;
    exp_rv = '0;
    exp_rd = '0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      exp_rv[r.port] = 1'b1;
      exp_rd[r.port] = r.data;
    end
    chk($sformatf("rvalid v%0d", n), DW'(rvalid_o), DW'(exp_rv));
    for (int p = 0; p < NP; p++)
      chk($sformatf("rdata v%0d p%0d", n, p), rdata_o[p], exp_rd[p]);
    if (v.chk) begin
      chk($sformatf("conflict_cnt v%0d", n), DW'(conflict_cnt_o), DW'(v.conf));
      chk($sformatf("illegal_wr_cnt v%0d", n), DW'(illegal_wr_cnt_o), DW'(v.ill));
    end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_ni = 1'b0;
    drive(mk('0, '0, '0, '0, '0, 0, 0, 0, 0, 0));
    #2;
    chk("reset gnt", DW'(gnt_o), '0);
    chk("reset rvalid", DW'(rvalid_o), '0);
    chk("reset rdata0", rdata_o[0], '0);
    chk("reset conflict_cnt", DW'(conflict_cnt_o), '0);
    chk("reset illegal_wr_cnt", DW'(illegal_wr_cnt_o), '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // preload words 0x00..0x78 and a zero word at 0x80
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(9'h100, 9'h100, 9'h100, pat(i), 8'hFF, 0, 0, 0, 0, 32'(i * 8)));
    vecs.push_back(cnt(mk(9'h100, 9'h100, 9'h100, '0, 8'hFF, 0, 0, 0, 0, 32'h80), 0, 0));
    // round-robin fairness on bank 0
    for (int i = 0; i < 6; i++) begin
      v = mk(9'h007, '0, 9'(1 << (i % 3)), '0, 8'hFF, 32'h00, 32'h20, 32'h40, 0, 0);
      vecs.push_back(i == 5 ? cnt(v, 6, 0) : v);
    end
    vecs.push_back(cnt(clr(mk('0, '0, '0, '0, '0, 0, 0, 0, 0, 0)), 0, 0));
    // host priority
    vecs.push_back(mk(9'h103, 9'h100, 9'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, 32'h20, 32'h20, 0, 0, 32'h20));
    vecs.push_back(mk(9'h003, '0, 9'h001, '0, 8'hFF, 32'h20, 32'h20, 0, 0, 0));
    vecs.push_back(cnt(mk(9'h002, '0, 9'h002, '0, 8'hFF, 0, 32'h20, 0, 0, 0), 2, 0));
    // parallel fetch across all four banks
    vecs.push_back(cnt(mk(9'h00F, '0, 9'h00F, '0, 8'hFF, 32'h00, 32'h08, 32'h10, 32'h18, 0), 2, 0));
    // byte enables
    vecs.push_back(mk(9'h100, 9'h100, 9'h100, '1, 8'h0F, 0, 0, 0, 0, 32'h80));
    vecs.push_back(mk(9'h100, '0, 9'h100, '0, 8'hFF, 0, 0, 0, 0, 32'h80));
    // illegal cluster writes, then host readback
    vecs.push_back(cnt(mk(9'h008, 9'h008, 9'h008, 64'h1234, 8'hFF, 0, 0, 0, 32'h40, 0), 2, 1));
    vecs.push_back(mk(9'h100, '0, 9'h100, '0, 8'hFF, 0, 0, 0, 0, 32'h40));
    vecs.push_back(cnt(mk(9'h006, 9'h006, 9'h006, 64'h55, 8'hFF, 0, 32'h48, 32'h50, 0, 0), 2, 3));
    vecs.push_back(mk(9'h100, '0, 9'h100, '0, 8'hFF, 0, 0, 0, 0, 32'h50));
    // address wrap
    vecs.push_back(mk(9'h104, '0, 9'h104, '0, 8'hFF, 0, 0, 32'(NBYTES + 8), 0, 32'hFFFF_8018));
    vecs.push_back(cnt(clr(mk('0, '0, '0, '0, '0, 0, 0, 0, 0, 0)), 0, 0));
    // saturation: host starves port 0 on bank 0
    for (int i = 1; i <= 16; i++) begin
      v = mk(9'h101, '0, 9'h100, '0, 8'hFF, 0, 0, 0, 0, 0);
      vecs.push_back(i >= 15 ? cnt(v, 15, 0) : v);
    end
    vecs.push_back(cnt(clr(mk(9'h101, '0, 9'h100, '0, 8'hFF, 0, 0, 0, 0, 0)), 0, 0));
    vecs.push_back(cnt(mk(9'h001, '0, 9'h001, '0, 8'hFF, 0, 0, 0, 0, 0), 0, 0));
    vecs.push_back(cnt(mk(9'h008, 9'h008, 9'h008, 64'h77, 8'hFF, 0, 0, 0, 32'h08, 0), 0, 1));

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], n);

    chk("byte enable literal", model[16], 64'h00000000_FFFFFFFF);

    // reset in a grant cycle with a conflict pending
    drive(mk(9'h003, '0, '0, '0, 8'hFF, 32'h08, 32'h08, 0, 0, 0));
    #4;
    chk("gnt before reset", DW'(gnt_o), DW'(9'h001));
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rvalid after reset", DW'(rvalid_o), '0);
    chk("rdata after reset", rdata_o[0], '0);
    chk("conflict_cnt after reset", DW'(conflict_cnt_o), '0);
    chk("illegal_wr_cnt after reset", DW'(illegal_wr_cnt_o), '0);
    @(negedge clk_i);
    drive(mk('0, '0, '0, '0, '0, 0, 0, 0, 0, 0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_vec(mk(9'h101, '0, 9'h101, '0, 8'hFF, 32'h08, 0, 0, 0, 32'h20), 1000);
    chk("contents kept over reset", model[4], 64'hDEADBEEF_CAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
